uart_rx_deframer: RTL and testbench
===================================

// Module: uart_rx_deframer
// PURPOSE
//  UART receive front end feeding the uart2bus command parser. Oversamples
//  ser_in 16x, validates the start bit, shifts in 8N1 data LSB first, and checks
//  the stop bit. Presents each good byte on a one-entry valid/ready holding
//  register. Flags framing errors and overruns as one-cycle pulses.
// PARAMETERS
//  OVS_DIV    27  clocks per oversample tick (clock / (baud*16)); 27 = 50 MHz @ 115200
//  OVS_DIV_W  12  width of the oversample tick counter; OVS_DIV must be < 2**OVS_DIV_W
// PORTS
//  clock      in   1  system clock, all logic on rising edge
//  reset      in   1  synchronous, active-high reset
//  ser_in     in   1  asynchronous serial line, idle high
//  rx_data    out  8  received byte, stable while rx_valid=1
//  rx_valid   out  1  holding register full
//  rx_ready   in   1  consumer accepts rx_data when rx_valid&&rx_ready
//  frame_err  out  1  1-cycle pulse: stop bit sampled 0, byte discarded
//  overrun    out  1  1-cycle pulse: good byte arrived while holding reg full and not accepted
//  busy       out  1  1 when state != IDLE
// BEHAVIOUR
//  - Reset: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0; state=IDLE;
//    both sync flops=1; tick/sample counters=0; armed=0.
//  - ser_in passes through a 2-flop synchronizer -> ser_s. Only ser_s is used.
//  - Tick generator: tick_cnt counts 0..OVS_DIV-1, tick=1 when tick_cnt==OVS_DIV-1.
//    Cleared to 0 on IDLE->START. smp_cnt (4 bit) increments on each tick; a bit lasts 16 ticks.
//  - armed: set when ser_s==1 in IDLE. Cleared on entering START. A start edge is
//    accepted only when armed=1, so a stuck-low line or break never re-triggers.
//  - Vote: ser_s is sampled on ticks with smp_cnt=7,8,9. vote=majority(3).
//    vote is evaluated on the tick where smp_cnt==9.
//  - FSM:
//    IDLE : ser_s==0 && armed -> START; tick_cnt=0, smp_cnt=0.
//    START: at smp_cnt==9, vote==1 -> IDLE (false start, no flags).
//           At smp_cnt==15, vote==0 -> DATA, bit_idx=0.
//    DATA : at smp_cnt==15, shreg={vote,shreg[7:1]}. bit_idx==7 -> STOP, else bit_idx++.
//    STOP : at smp_cnt==9 -> IDLE immediately, without waiting for the rest of the bit.
//           vote==1 -> good byte.
//           vote==0 -> frame_err pulse next cycle; byte dropped; armed stays 0 until line high.
//  - Output reg, evaluated in the cycle after a good byte is decided:
//    - !rx_valid, or rx_valid&&rx_ready in that same cycle: load rx_data=shreg, rx_valid=1.
//      A simultaneous accept and new byte is NOT an overrun.
//    - rx_valid&&!rx_ready: overrun=1 for one cycle; rx_data and rx_valid are unchanged.
//    - Otherwise rx_valid&&rx_ready clears rx_valid on the next edge.
//  - Latency: rx_valid rises 1 clock after the STOP smp_cnt==9 tick. From the
//    ser_in edge, add 2 clocks of synchronizer delay.
//  - reset mid-frame: abort immediately to reset values. The partial byte is
//    never delivered. Reception resumes only after ser_s==1 is seen (armed).
//  - frame_err and overrun are never high together. Neither is sticky.
// TESTING  (OVS_DIV=4, so 1 bit = 64 clocks)
//  1. Send 0x52 8N1, rx_ready=1 -> rx_valid 1-cycle, rx_data=0x52, frame_err=0, overrun=0.
//  2. Pulse ser_in low for 8 clocks, then high -> busy rises then falls, no rx_valid, no flags.
//  3. Send 0x77 with stop=0, hold low 20 bit times -> one frame_err pulse, no rx_valid;
//     after line high, 0x0D is received OK.
//  4. Send 0x72 then 0x0D back-to-back, rx_ready=0 -> rx_data=0x72 held;
//     overrun pulses once at 2nd stop.
//  5. Assert reset during data bit 3 of 0x57 -> all outputs 0; next frame 0x20 received exactly.
//  6. Raise rx_ready in the exact cycle the 2nd byte 0x09 completes -> rx_data=0x09,
//     rx_valid stays 1, overrun=0.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// UART 8N1 receiver front end: 16x oversampling, 3-sample majority vote,
// one-entry valid/ready holding register with framing-error and overrun pulses.
module uart_rx_deframer #(
   parameter int OVS_DIV   = 27,
   parameter int OVS_DIV_W = 12
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ser_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                state_reg, state_next;
   logic                  sync1_reg, ser_s_reg;
   logic [OVS_DIV_W-1:0]  tick_cnt_reg;
   logic [3:0]            smp_cnt_reg;
   logic [1:0]            smp_reg;
   logic                  vote_reg;
   logic [7:0]            shreg_reg;
   logic [2:0]            bit_idx_reg;
   logic                  armed_reg;
   logic                  good_reg;
   logic                  frame_err_reg;
   logic                  overrun_reg;
   logic [7:0]            rx_data_reg;
   logic                  rx_valid_reg;

   logic tick;
   logic vote_now;
   logic start_frame;
   logic shift_bit;
   logic good_byte;
   logic bad_stop;

   assign tick     = (tick_cnt_reg == OVS_DIV_W'(OVS_DIV - 1));
   // Third sample is the live synchronized line on the smp_cnt==9 tick.
   assign vote_now = (smp_reg[0] & smp_reg[1]) | (smp_reg[0] & ser_s_reg) | (smp_reg[1] & ser_s_reg);

   always_comb begin
      state_next  = state_reg;
      start_frame = 1'b0;
      shift_bit   = 1'b0;
      good_byte   = 1'b0;
      bad_stop    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!ser_s_reg && armed_reg) begin
               state_next  = START;
               start_frame = 1'b1;
            end
         end
         START: begin
            if (tick && smp_cnt_reg == 4'd9 && vote_now)
               state_next = IDLE;
            else if (tick && smp_cnt_reg == 4'd15 && !vote_reg)
               state_next = DATA;
         end
         DATA: begin
            if (tick && smp_cnt_reg == 4'd15) begin
               shift_bit = 1'b1;
               if (bit_idx_reg == 3'd7)
                  state_next = STOP;
            end
         end
         STOP: begin
            // Decide at mid-stop so a back-to-back start edge is never missed.
            if (tick && smp_cnt_reg == 4'd9) begin
               state_next = IDLE;
               good_byte  = vote_now;
               bad_stop   = !vote_now;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= IDLE;
         sync1_reg     <= 1'b1;
         ser_s_reg     <= 1'b1;
         tick_cnt_reg  <= '0;
         smp_cnt_reg   <= '0;
         smp_reg       <= '0;
         vote_reg      <= 1'b0;
         shreg_reg     <= '0;
         bit_idx_reg   <= '0;
         armed_reg     <= 1'b0;
         good_reg      <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         sync1_reg     <= ser_in;
         ser_s_reg     <= sync1_reg;
         good_reg      <= good_byte;
         frame_err_reg <= bad_stop;

         if (start_frame || tick)
            tick_cnt_reg <= '0;
         else
            tick_cnt_reg <= tick_cnt_reg + OVS_DIV_W'(1);

         if (start_frame)
            smp_cnt_reg <= '0;
         else if (tick)
            smp_cnt_reg <= smp_cnt_reg + 4'd1;

         if (tick && smp_cnt_reg == 4'd7) smp_reg[0] <= ser_s_reg;
         if (tick && smp_cnt_reg == 4'd8) smp_reg[1] <= ser_s_reg;
         if (tick && smp_cnt_reg == 4'd9) vote_reg   <= vote_now;

         if (start_frame)
            bit_idx_reg <= '0;
         else if (shift_bit)
            bit_idx_reg <= bit_idx_reg + 3'd1;

         if (shift_bit)
            shreg_reg <= {vote_reg, shreg_reg[7:1]};

         // Re-arm only on a high line so a break or stuck-low line cannot retrigger.
         if (start_frame)
            armed_reg <= 1'b0;
         else if (state_reg == IDLE && ser_s_reg)
            armed_reg <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_data_reg  <= '0;
         rx_valid_reg <= 1'b0;
         overrun_reg  <= 1'b0;
      end else begin
         overrun_reg <= 1'b0;
         if (good_reg) begin
            if (!rx_valid_reg || rx_ready) begin
               rx_data_reg  <= shreg_reg;
               rx_valid_reg <= 1'b1;
            end else begin
               overrun_reg <= 1'b1;
            end
         end else if (rx_valid_reg && rx_ready) begin
            rx_valid_reg <= 1'b0;
         end
      end
   end

   assign rx_data   = rx_data_reg;
   assign rx_valid  = rx_valid_reg;
   assign frame_err = frame_err_reg;
   assign overrun   = overrun_reg;
   assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer with OVS_DIV=4 (one bit = 64 clocks).
module tb_uart_rx_deframer;

   localparam int BIT = 64;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       ser_in = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int checks = 0;
   int errors = 0;

   // Event counters, written only by the monitor below.
   int         fe_cnt = 0;
   int         ov_cnt = 0;
   int         vld_rise = 0;
   int         vld_cyc = 0;
   int         busy_rise = 0;
   int         both_cnt = 0;
   logic [7:0] last_data = 8'h00;
   logic       vld_d = 1'b0;
   logic       busy_d = 1'b0;

   uart_rx_deframer #(.OVS_DIV(4), .OVS_DIV_W(12)) dut (
      .clock    (clock),
      .reset    (reset),
      .ser_in   (ser_in),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .frame_err(frame_err),
      .overrun  (overrun),
      .busy     (busy)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (overrun) ov_cnt <= ov_cnt + 1;
      if (frame_err && overrun) both_cnt <= both_cnt + 1;
      if (rx_valid) vld_cyc <= vld_cyc + 1;
      if (busy && !busy_d) busy_rise <= busy_rise + 1;
      if (rx_valid && !vld_d) begin
         vld_rise  <= vld_rise + 1;
         last_data <= rx_data;
         $display("[%0t] rx byte 0x%02h", $time, rx_data);
      end
      vld_d  <= rx_valid;
      busy_d <= busy;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      ser_in = 1'b0;
      repeat (BIT) step();
      for (int i = 0; i < 8; i++) begin
         ser_in = b[i];
         repeat (BIT) step();
      end
      ser_in = stop_bit;
      repeat (BIT) step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ser_in = 1'b1;
      repeat (4) step();
      @(negedge clock);
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      step();
      reset = 1'b0;
      repeat (2 * BIT) step();
   endtask

   task automatic test_single_byte();
      int r0, c0, f0, o0;
      r0 = vld_rise; c0 = vld_cyc; f0 = fe_cnt; o0 = ov_cnt;
      rx_ready = 1'b1;
      send_frame(8'h52, 1'b1);
      repeat (BIT) step();
      checks++; if (vld_rise - r0 !== 1) begin errors++; $display("FAIL single_count got %0d want 1", vld_rise - r0); end
      checks++; if (vld_cyc - c0 !== 1) begin errors++; $display("FAIL single_valid_width got %0d want 1", vld_cyc - c0); end
      checks++; if (last_data !== 8'h52) begin errors++; $display("FAIL single_data got %h want 52", last_data); end
      checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL single_frame_err got %0d want 0", fe_cnt - f0); end
      checks++; if (ov_cnt - o0 !== 0) begin errors++; $display("FAIL single_overrun got %0d want 0", ov_cnt - o0); end
   endtask

   task automatic test_false_start();
      int r0, f0, o0, b0;
      r0 = vld_rise; f0 = fe_cnt; o0 = ov_cnt; b0 = busy_rise;
      ser_in = 1'b0;
      repeat (8) step();
      ser_in = 1'b1;
      repeat (2 * BIT) step();
      @(negedge clock);
      checks++; if (busy_rise - b0 !== 1) begin errors++; $display("FAIL false_busy_rise got %0d want 1", busy_rise - b0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL false_busy_end got %b want 0", busy); end
      checks++; if (vld_rise - r0 !== 0) begin errors++; $display("FAIL false_valid got %0d want 0", vld_rise - r0); end
      checks++; if ((fe_cnt - f0) + (ov_cnt - o0) !== 0) begin errors++; $display("FAIL false_flags got %0d want 0", (fe_cnt - f0) + (ov_cnt - o0)); end
      step();
   endtask

   task automatic test_frame_err();
      int r0, f0, o0;
      r0 = vld_rise; f0 = fe_cnt; o0 = ov_cnt;
      rx_ready = 1'b1;
      send_frame(8'h77, 1'b0);
      repeat (20 * BIT) step();
      checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_pulses got %0d want 1", fe_cnt - f0); end
      checks++; if (vld_rise - r0 !== 0) begin errors++; $display("FAIL ferr_valid got %0d want 0", vld_rise - r0); end
      ser_in = 1'b1;
      repeat (2 * BIT) step();
      send_frame(8'h0D, 1'b1);
      repeat (BIT) step();
      checks++; if (vld_rise - r0 !== 1) begin errors++; $display("FAIL ferr_recover_count got %0d want 1", vld_rise - r0); end
      checks++; if (last_data !== 8'h0D) begin errors++; $display("FAIL ferr_recover_data got %h want 0d", last_data); end
      checks++; if (fe_cnt - f0 !== 1 || ov_cnt - o0 !== 0) begin errors++; $display("FAIL ferr_flags fe %0d ov %0d want 1 0", fe_cnt - f0, ov_cnt - o0); end
   endtask

   task automatic test_back_to_back();
      int o0, f0;
      o0 = ov_cnt; f0 = fe_cnt;
      rx_ready = 1'b0;
      send_frame(8'h72, 1'b1);
      send_frame(8'h0D, 1'b1);
      repeat (BIT) step();
      @(negedge clock);
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", rx_valid); end
      checks++; if (rx_data !== 8'h72) begin errors++; $display("FAIL b2b_data got %h want 72", rx_data); end
      checks++; if (ov_cnt - o0 !== 1) begin errors++; $display("FAIL b2b_overrun got %0d want 1", ov_cnt - o0); end
      checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL b2b_frame_err got %0d want 0", fe_cnt - f0); end
      step();
   endtask

   task automatic test_mid_reset();
      int r0;
      logic [7:0] b;
      b = 8'h57;
      rx_ready = 1'b0;
      ser_in = 1'b0;
      repeat (BIT) step();
      for (int i = 0; i < 3; i++) begin
         ser_in = b[i];
         repeat (BIT) step();
      end
      ser_in = b[3];
      repeat (BIT / 2) step();
      @(negedge clock);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b want 1", busy); end
      step();
      reset = 1'b1;
      ser_in = 1'b1;
      step();
      @(negedge clock);
      checks++; if ({rx_valid, rx_data, frame_err, overrun, busy} !== 12'h000) begin
         errors++; $display("FAIL midrst_outputs got v%b d%h fe%b ov%b b%b want all 0", rx_valid, rx_data, frame_err, overrun, busy);
      end
      step();
      reset = 1'b0;
      r0 = vld_rise;
      repeat (2 * BIT) step();
      rx_ready = 1'b1;
      send_frame(8'h20, 1'b1);
      repeat (BIT) step();
      checks++; if (vld_rise - r0 !== 1) begin errors++; $display("FAIL midrst_count got %0d want 1", vld_rise - r0); end
      checks++; if (last_data !== 8'h20) begin errors++; $display("FAIL midrst_data got %h want 20", last_data); end
   endtask

   task automatic test_ready_same_cycle();
      int o0;
      rx_ready = 1'b0;
      send_frame(8'h41, 1'b1);
      o0 = ov_cnt;
      fork
         send_frame(8'h09, 1'b1);
         begin
            // good byte is decided 619 edges after the start bit is driven
            repeat (619) @(posedge clock);
            #1 rx_ready = 1'b1;
            @(posedge clock);
            #1 rx_ready = 1'b0;
         end
      join
      repeat (BIT) step();
      @(negedge clock);
      checks++; if (rx_data !== 8'h09) begin errors++; $display("FAIL same_cycle_data got %h want 09", rx_data); end
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL same_cycle_valid got %b want 1", rx_valid); end
      checks++; if (ov_cnt - o0 !== 0) begin errors++; $display("FAIL same_cycle_overrun got %0d want 0", ov_cnt - o0); end
      step();
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
      @(negedge clock);
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL accept_clear got %b want 0", rx_valid); end
      step();
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_false_start();
      test_frame_err();
      test_back_to_back();
      test_mid_reset();
      test_ready_same_cycle();
      checks++; if (both_cnt !== 0) begin errors++; $display("FAIL flags_exclusive got %0d want 0", both_cnt); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
